// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoder bundle and ID operands in, registered EX-side copies out.
// The slave modport is the stage itself; the master modport is the ID-side driver.
interface id_ex_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic [6:0]            Opcode_i;
    logic                  ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i;
    logic                  MemWrite_i, Branch_i, Jump_i, CurrFlag_i;
    logic [2:0]            ALUOp_i;
    logic                  valid_i;
    logic [DATA_W-1:0]     pc_i, rd1_i, rd2_i, imm_i;
    logic [REG_ADDR_W-1:0] rs1_i, rs2_i, rd_i;
    logic [2:0]            funct3_i;
    logic [6:0]            funct7_i;
    logic                  hold_i;
    logic                  flush_i;

    logic                  ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o;
    logic                  MemWrite_o, Branch_o, Jump_o, CurrFlag_o;
    logic [2:0]            ALUOp_o;
    logic                  valid_o;
    logic [DATA_W-1:0]     pc_o, rd1_o, rd2_o, imm_o;
    logic [REG_ADDR_W-1:0] rs1_o, rs2_o, rd_o;
    logic [2:0]            funct3_o;
    logic [6:0]            funct7_o;
    logic                  stall_o;
    logic [31:0]           stall_cnt_o, flush_cnt_o;

    modport slave (
        input  Opcode_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i,
               Branch_i, Jump_i, CurrFlag_i, ALUOp_i, valid_i, pc_i, rd1_i, rd2_i,
               imm_i, rs1_i, rs2_i, rd_i, funct3_i, funct7_i, hold_i, flush_i,
        output ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o,
               Jump_o, CurrFlag_o, ALUOp_o, valid_o, pc_o, rd1_o, rd2_o, imm_o,
               rs1_o, rs2_o, rd_o, funct3_o, funct7_o, stall_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output Opcode_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i,
               Branch_i, Jump_i, CurrFlag_i, ALUOp_i, valid_i, pc_i, rd1_i, rd2_i,
               imm_i, rs1_i, rs2_i, rd_i, funct3_i, funct7_i, hold_i, flush_i,
        input  ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o,
               Jump_o, CurrFlag_o, ALUOp_o, valid_o, pc_o, rd1_o, rd2_o, imm_o,
               rs1_o, rs2_o, rd_o, funct3_o, funct7_o, stall_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional stall/flush performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);
    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic              w_rs1_live;
    logic              w_rs2_live;
    logic              w_lu;
    logic              w_load;
    logic              w_bubble;
    logic [CTRL_W-1:0] w_ctrl_in;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic              w_valid_nxt;
    logic [REG_ADDR_W-1:0] w_rd_nxt;

    // Source-register liveness and load-use detection against the EX slot
    always_comb begin
        w_rs1_live = 1'b0;
        w_rs2_live = 1'b0;
        case (bus.Opcode_i)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                w_rs1_live = 1'b1;
                w_rs2_live = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: w_rs1_live = 1'b1;
            default: ;
        endcase
        w_lu = bus.valid_i && bus.MemRead_o && bus.valid_o && (bus.rd_o != '0) &&
               ((w_rs1_live && (bus.rs1_i == bus.rd_o)) ||
                (w_rs2_live && (bus.rs2_i == bus.rd_o)));
    end

    assign bus.stall_o = w_lu & ~bus.flush_i;

    // Per-edge update: flush beats hold, hold beats load-use, else load
    always_comb begin
        w_ctrl_in   = {bus.ALUSrc_i, bus.MemtoReg_i, bus.RegWrite_i, bus.MemRead_i,
                       bus.MemWrite_i, bus.Branch_i, bus.Jump_i, bus.CurrFlag_i, bus.ALUOp_i};
        w_load      = bus.flush_i | ~bus.hold_i;
        w_bubble    = bus.flush_i | w_lu;
        w_ctrl_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_rd_nxt    = '0;
        if (!w_bubble) begin
            w_ctrl_nxt  = bus.valid_i ? w_ctrl_in : '0;
            w_valid_nxt = bus.valid_i;
            w_rd_nxt    = bus.rd_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {bus.ALUSrc_o, bus.MemtoReg_o, bus.RegWrite_o, bus.MemRead_o,
             bus.MemWrite_o, bus.Branch_o, bus.Jump_o, bus.CurrFlag_o, bus.ALUOp_o} <= '0;
            bus.valid_o  <= 1'b0;
            bus.pc_o     <= '0;
            bus.rd1_o    <= '0;
            bus.rd2_o    <= '0;
            bus.imm_o    <= '0;
            bus.rs1_o    <= '0;
            bus.rs2_o    <= '0;
            bus.rd_o     <= '0;
            bus.funct3_o <= '0;
            bus.funct7_o <= '0;
        end else if (w_load) begin
            {bus.ALUSrc_o, bus.MemtoReg_o, bus.RegWrite_o, bus.MemRead_o,
             bus.MemWrite_o, bus.Branch_o, bus.Jump_o, bus.CurrFlag_o, bus.ALUOp_o} <= w_ctrl_nxt;
            bus.valid_o  <= w_valid_nxt;
            bus.pc_o     <= bus.pc_i;
            bus.rd1_o    <= bus.rd1_i;
            bus.rd2_o    <= bus.rd2_i;
            bus.imm_o    <= bus.imm_i;
            bus.rs1_o    <= bus.rs1_i;
            bus.rs2_o    <= bus.rs2_i;
            bus.rd_o     <= w_rd_nxt;
            bus.funct3_o <= bus.funct3_i;
            bus.funct7_o <= bus.funct7_i;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall_o && !bus.hold_i && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (bus.flush_i && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (load-use, flush, hold, reset).
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    id_ex_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic mr, input logic rw,
                          input logic mw, input logic jmp, input logic [2:0] aluop,
                          input logic [31:0] pc);
        bus.Opcode_i   = op;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.rd_i       = rd;
        bus.MemRead_i  = mr;
        bus.MemtoReg_i = mr;
        bus.RegWrite_i = rw;
        bus.MemWrite_i = mw;
        bus.ALUSrc_i   = mr | mw;
        bus.Jump_i     = jmp;
        bus.Branch_i   = 1'b0;
        bus.CurrFlag_i = 1'b0;
        bus.ALUOp_i    = aluop;
        bus.valid_i    = 1'b1;
        bus.pc_i       = pc;
        bus.rd1_i      = pc ^ 32'h1111_0000;
        bus.rd2_i      = pc ^ 32'h0000_2222;
        bus.imm_i      = 32'h0000_0010;
        bus.funct3_i   = 3'b010;
        bus.funct7_i   = 7'b0;
    endtask

    task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
        set_id(7'b0000011, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0100);
    endtask

    task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_id(7'b0110011, rs1, rs2, rd, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0104);
    endtask

    task automatic do_reset();
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.MemRead_o !== 1'b0 || bus.RegWrite_o !== 1'b0 ||
            bus.rd_o !== 5'd0 || bus.pc_o !== 32'd0 || bus.ALUOp_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async got valid=%b mr=%b rw=%b rd=%0d pc=%h required all 0",
                     bus.valid_o, bus.MemRead_o, bus.RegWrite_o, bus.rd_o, bus.pc_o);
        end
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got %b required 0", bus.stall_o);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd6 || bus.RegWrite_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release got valid=%b rd=%0d rw=%b required 1/6/1",
                     bus.valid_o, bus.rd_o, bus.RegWrite_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw(5'd5, 5'd1);
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.MemRead_o !== 1'b1 || bus.rd_o !== 5'd5 ||
            bus.pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL lw_in_ex got valid=%b mr=%b rd=%0d pc=%h required 1/1/5/100",
                     bus.valid_o, bus.MemRead_o, bus.rd_o, bus.pc_o);
        end
        set_add(5'd6, 5'd5, 5'd7);
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_rs1_stall got %b required 1", bus.stall_o);
        end
        step();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.MemRead_o !== 1'b0 ||
            bus.rd_o !== 5'd0 || bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble got valid=%b rw=%b mr=%b rd=%0d stall=%b required 0/0/0/0/0",
                     bus.valid_o, bus.RegWrite_o, bus.MemRead_o, bus.rd_o, bus.stall_o);
        end
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.RegWrite_o !== 1'b1 || bus.ALUOp_o !== 3'b010 ||
            bus.rd_o !== 5'd6 || bus.rs1_o !== 5'd5) begin
            n_fail++;
            $display("FAIL lu_release got valid=%b rw=%b aluop=%b rd=%0d required 1/1/010/6",
                     bus.valid_o, bus.RegWrite_o, bus.ALUOp_o, bus.rd_o);
        end
    endtask

    task automatic test_store_rs2();
        do_reset();
        set_lw(5'd5, 5'd1);
        step();
        set_id(7'b0100011, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h108);
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_rs2_stall got %b required 1", bus.stall_o);
        end
        step();
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.MemWrite_o !== 1'b1 || bus.rs2_o !== 5'd5) begin
            n_fail++;
            $display("FAIL sw_release got valid=%b mw=%b rs2=%0d required 1/1/5",
                     bus.valid_o, bus.MemWrite_o, bus.rs2_o);
        end
    endtask

    task automatic test_no_source();
        do_reset();
        set_lw(5'd5, 5'd1);
        step();
        set_id(7'b1101111, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h10c);
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_no_stall got %b required 0", bus.stall_o);
        end
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.Jump_o !== 1'b1 || bus.rd_o !== 5'd1) begin
            n_fail++;
            $display("FAIL jal_enter got valid=%b jump=%b rd=%0d required 1/1/1",
                     bus.valid_o, bus.Jump_o, bus.rd_o);
        end
        // lw x0 never creates a hazard
        set_lw(5'd0, 5'd1);
        step();
        set_add(5'd6, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_x0_no_stall got %b required 0", bus.stall_o);
        end
    endtask

    task automatic test_invalid_and_hold();
        do_reset();
        set_add(5'd9, 5'd3, 5'd4);
        bus.valid_i = 1'b0;
        step();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.ALUOp_o !== 3'b000) begin
            n_fail++;
            $display("FAIL invalid_ctrl got valid=%b rw=%b aluop=%b required 0/0/000",
                     bus.valid_o, bus.RegWrite_o, bus.ALUOp_o);
        end
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd7);
        bus.hold_i = 1'b1;
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stall got %b required 1", bus.stall_o);
        end
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.MemRead_o !== 1'b1 || bus.rd_o !== 5'd5 ||
            bus.pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL hold_keep got valid=%b mr=%b rd=%0d pc=%h required 1/1/5/100",
                     bus.valid_o, bus.MemRead_o, bus.rd_o, bus.pc_o);
        end
        bus.hold_i = 1'b0;
        step();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.rd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL hold_then_bubble got valid=%b rd=%0d required 0/0",
                     bus.valid_o, bus.rd_o);
        end
        n_checks++;
        if (bus.stall_cnt_o !== 32'd`ifdef ID_EX_PERF_EN 1 `else 0 `endif) begin
            n_fail++;
            $display("FAIL hold_stall_cnt got %0d", bus.stall_cnt_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd7);
        bus.flush_i = 1'b1;
        bus.hold_i  = 1'b1;
        #1;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall got %b required 0", bus.stall_o);
        end
        step();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.MemRead_o !== 1'b0 || bus.RegWrite_o !== 1'b0 ||
            bus.rd_o !== 5'd0 || bus.pc_o !== 32'h104) begin
            n_fail++;
            $display("FAIL flush_bubble got valid=%b mr=%b rw=%b rd=%0d pc=%h required 0/0/0/0/104",
                     bus.valid_o, bus.MemRead_o, bus.RegWrite_o, bus.rd_o, bus.pc_o);
        end
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
`ifdef ID_EX_PERF_EN
        n_checks++;
        if (bus.flush_cnt_o !== 32'd1 || bus.stall_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_counters got flush=%0d stall=%0d required 1/0",
                     bus.flush_cnt_o, bus.stall_cnt_o);
        end
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd7);
        step();
        n_checks++;
        if (bus.stall_cnt_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stall_cnt_sat got %h required ffffffff", bus.stall_cnt_o);
        end
`else
        n_checks++;
        if (bus.flush_cnt_o !== 32'd0 || bus.stall_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL counters_tied got flush=%0d stall=%0d required 0/0",
                     bus.flush_cnt_o, bus.stall_cnt_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int stalls;
        do_reset();
        stalls = 0;
        set_lw(5'd5, 5'd1);
        step();
        set_lw(5'd6, 5'd5);
        #1;
        if (bus.stall_o === 1'b1) stalls++;
        step();
        if (bus.stall_o === 1'b1) stalls++;
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.MemRead_o !== 1'b1 || bus.rd_o !== 5'd6) begin
            n_fail++;
            $display("FAIL b2b_second_lw got valid=%b mr=%b rd=%0d required 1/1/6",
                     bus.valid_o, bus.MemRead_o, bus.rd_o);
        end
        set_add(5'd7, 5'd2, 5'd6);
        #1;
        if (bus.stall_o === 1'b1) stalls++;
        step();
        if (bus.stall_o === 1'b1) stalls++;
        step();
        n_checks++;
        if (stalls !== 2) begin
            n_fail++;
            $display("FAIL b2b_stall_cycles got %0d required 2", stalls);
        end
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd7 || bus.ALUOp_o !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_add got valid=%b rd=%0d aluop=%b required 1/7/010",
                     bus.valid_o, bus.rd_o, bus.ALUOp_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        set_add(5'd0, 5'd0, 5'd0);
        bus.valid_i = 1'b0;
        #2;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.rd_o !== 5'd0 ||
            bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL power_on_reset got valid=%b rw=%b rd=%0d required 0/0/0",
                     bus.valid_o, bus.RegWrite_o, bus.rd_o);
        end
        test_reset();
        test_load_use();
        test_store_rs2();
        test_no_source();
        test_invalid_and_hold();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the RISC-V core, directly downstream of the opcode decoder.
- Registers the decoder's control bundle together with the ID-stage operands and register indices.
- Detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and freezes PC and IF/ID.
- Applies a flush from branch/jump resolution in EX.

Parameters:
- DATA_W, 32, width of PC, read data 1/2 and immediate.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Opcode_i  input  7  opcode of the ID instruction; used only to decide whether rs1/rs2 are live
- ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i, Branch_i, Jump_i, CurrFlag_i  input  1 each  decoder control bits
- ALUOp_i  input  3  decoder ALU operation class
- valid_i  input  1  ID slot holds a real instruction
- pc_i, rd1_i, rd2_i, imm_i  input  DATA_W each  ID-stage values
- rs1_i, rs2_i, rd_i  input  REG_ADDR_W each  register indices
- funct3_i  input  3; funct7_i  input  7
- hold_i  input  1  external freeze (data-memory wait)
- flush_i  input  1  branch taken / jump resolved in EX
- ALUSrc_o … CurrFlag_o, ALUOp_o, valid_o, pc_o, rd1_o, rd2_o, imm_o, rs1_o, rs2_o, rd_o, funct3_o, funct7_o  output  same widths  registered EX-side copies
- stall_o  output  1  combinational; freeze PC and IF/ID this cycle
- stall_cnt_o, flush_cnt_o  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): every registered output is 0, so valid_o=0 and all control bits are 0. Counters are 0.
- Latency: 1 cycle. Inputs sampled on a rising clk edge appear on the outputs after that edge.
- rs1 is live for opcodes 0110011, 0000011, 0100011, 1100011, 0010011, 1100111.
- rs2 is live for opcodes 0110011, 0100011, 1100011.
- All other opcodes, including 1101111, read no source register.
- Load-use hazard (lu) is asserted when all of the following hold:
  - valid_i=1, MemRead_o=1, valid_o=1 and rd_o≠0;
  - (rs1 live and rs1_i==rd_o) or (rs2 live and rs2_i==rd_o).
- Bubble definition: all control outputs = 0, valid_o=0, rd_o=0. Datapath fields are don't-care and are loaded from the inputs.
- Per-edge priority, highest first:
  1. flush_i: load a bubble, regardless of hold_i and lu.
  2. hold_i: keep every register unchanged.
  3. lu: load a bubble.
  4. Otherwise: load the inputs. If valid_i=0, force all control outputs to 0.
- stall_o = lu & ~flush_i. stall_o is independent of hold_i; the core ORs hold_i into the IF freeze itself.
- A load-use stall lasts exactly 1 cycle. The bubble clears MemRead_o, so lu drops on the next cycle and the held instruction then enters EX.
- rd_o=0 never triggers a hazard, including lw x0.
- Back-to-back loads with a dependency each stall 1 cycle.
- Releasing reset mid-stream: first edge after deassertion behaves as normal operation from the all-zero state.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - stall_cnt_o increments on each edge where stall_o=1 and hold_i=0.
  - flush_cnt_o increments on each edge where flush_i=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesized.

Test Plan:
1. Reset asserted mid-run with a valid lw in EX → all outputs 0 immediately (before the next edge); stall_o=0.
2. lw x5 (Opcode 0000011) registered in EX, then add x6,x5,x7 in ID (Opcode 0110011, rs1=5):
   - stall_o=1 for 1 cycle; EX receives a bubble (valid_o=0, RegWrite_o=0);
   - the add enters EX on the next edge with RegWrite_o=1, ALUOp_o=010.
3. lw x5 in EX, then sw in ID with rs2=5, rs1=2 → stall.
4. lw x5 in EX, then jal x1 in ID (Opcode 1101111, rs1/rs2 fields =5) → no stall, since jal reads no register.
5. lw x0 in EX, then add rs1=0 → stall_o=0.
6. flush_i=1 coinciding with a load-use hazard and hold_i=1 → bubble loaded, stall_o=0.
   - With ID_EX_PERF_EN: flush_cnt_o goes 0→1 and stall_cnt_o stays 0.
   - Forced saturation test: stall_cnt_o preloaded at 0xFFFFFFFF stays at 0xFFFFFFFF after a further stall.
